fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the control unit.
- Owns the 8-bit program counter and fetches one 8-bit instruction at a time from instruction memory over a req/ack handshake.
- Holds each instruction stable on `instruction` for the control unit, then advances to PC+1 or redirects to a jump target.
- Redirect happens when the control unit's `jump` output reads all-ones.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_unit.sv | 80 ++++++++
 tb/tb_fetch_unit.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch/control definitions: FSM encoding, jump sentinel, default widths and decode opcodes.
// Pure declarations; no logic, no latency.
package cpu_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 8;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } fetch_state_t;

    // The control unit drives all-ones to request a redirect; any other pattern is "not taken".
    localparam logic [7:0] JUMP_TAKEN = 8'hFF;

    localparam logic [3:0] OPCODE_J   = 4'b1000;
    localparam logic [3:0] OPCODE_JAL = 4'b1001;
    localparam logic [3:0] OPCODE_BEQ = 4'b1100;
    localparam logic [3:0] OPCODE_BNE = 4'b1101;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, fetches over req/ack, issues one instruction at a time (>=2 cycles each).
// Backpressure: stall freezes the issued instruction; imem_req is held until imem_ack.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic [7:0]         jump,
    input  logic [ADDR_W-1:0]  jump_target,
    input  logic               stall,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  w_fetch_pc_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               w_load;

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_load         = 1'b0;
        case (r_state)
            // One idle cycle so an ack belonging to a fetch killed by reset is never captured.
            S_BOOT: w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    w_load         = 1'b1;
                    w_fetch_pc_nxt = r_fetch_pc + 1'b1;
                    w_state_nxt    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    w_state_nxt = S_FETCH;
                    if (jump == JUMP_TAKEN) begin
                        w_fetch_pc_nxt = jump_target;
                    end
                end
            end
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_BOOT;
            r_fetch_pc <= RESET_PC;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            if (w_load) begin
                r_instr <= imem_rdata;
                r_pc    <= r_fetch_pc;
            end
        end
    end

    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = r_fetch_pc;
    assign instr_valid = (r_state == S_ISSUE);
    assign instruction = r_instr;
    assign pc          = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a program-level model predicts fetch addresses and
// issued (pc, instruction) pairs; a negedge monitor pops and compares whenever the DUT presents them.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic [7:0] jump;
    logic [7:0] jump_target;
    logic       stall;
    logic [7:0] instruction;
    logic       instr_valid;
    logic [7:0] pc;

    fetch_unit #(.ADDR_W(8), .INSTR_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .jump(jump), .jump_target(jump_target), .stall(stall),
        .instruction(instruction), .instr_valid(instr_valid), .pc(pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] ins;
    } exp_t;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] mem [256];
    logic [7:0] addr_q [$];
    exp_t       exp_q [$];
    logic [7:0] m_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic finish_tb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input bit want_valid, input string nm);
        int n = 0;
        while (((want_valid ? instr_valid : imem_req) !== 1'b1) && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL timeout waiting for %s at %0t", nm, $time);
            finish_tb();
        end
    endtask

    // One complete fetch/issue round trip; the model decides the next fetch address from the
    // redirect decision presented on the cycle stall is released.
    task automatic do_fetch(input int lat, input int stall_n, input logic [7:0] jmp, input logic [7:0] tgt);
        logic [7:0] cur;
        wait_for(1'b0, "imem_req");
        cur = m_addr;
        for (int i = 1; i < lat; i++) begin
            imem_ack    = 1'b0;
            jump        = JUMP_TAKEN;
            jump_target = 8'($urandom);
            step();
        end
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr];
        exp_q.push_back('{pc: cur, ins: mem[cur]});
        step();
        imem_ack = 1'b0;
        wait_for(1'b1, "instr_valid");
        for (int i = 0; i < stall_n; i++) begin
            stall       = 1'b1;
            jump        = JUMP_TAKEN;
            jump_target = 8'($urandom);
            imem_ack    = 1'($urandom);
            imem_rdata  = 8'($urandom);
            step();
        end
        stall       = 1'b0;
        jump        = jmp;
        jump_target = tgt;
        imem_ack    = 1'($urandom);
        imem_rdata  = 8'($urandom);
        m_addr      = (jmp == JUMP_TAKEN) ? tgt : cur + 8'd1;
        addr_q.push_back(m_addr);
        step();
        imem_ack    = 1'b0;
        jump        = JUMP_TAKEN;
        jump_target = 8'($urandom);
    endtask

    // Monitor
    logic       prev_req, prev_valid, prev_ackedge, prev_rst;
    logic [7:0] prev_instr, cur_addr;
    exp_t       held;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req", imem_req, 1'b0);
            chk("rst_valid", instr_valid, 1'b0);
            chk("rst_instr", instruction, 8'h00);
            chk("rst_pc", pc, 8'h00);
            prev_req     = 1'b0;
            prev_valid   = 1'b0;
            prev_ackedge = 1'b0;
            prev_rst     = 1'b1;
        end else begin
            if (imem_req && instr_valid) begin
                checks++;
                failures++;
                $display("FAIL req_and_valid: both high at %0t", $time);
            end
            if (imem_req) begin
                if (!prev_req) begin
                    if (addr_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_req: addr %0h with nothing expected", imem_addr);
                        cur_addr = imem_addr;
                    end else begin
                        cur_addr = addr_q.pop_front();
                    end
                end
                chk("imem_addr", imem_addr, cur_addr);
            end
            if (prev_ackedge) chk("valid_after_ack", instr_valid, 1'b1);
            if (instr_valid) begin
                if (!prev_valid) begin
                    if (!prev_ackedge) begin
                        checks++;
                        failures++;
                        $display("FAIL valid_without_ack: instr %0h at %0t", instruction, $time);
                    end
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_issue: instr %0h pc %0h", instruction, pc);
                        held = '{pc: pc, ins: instruction};
                    end else begin
                        held = exp_q.pop_front();
                    end
                end
                chk("instruction", instruction, held.ins);
                chk("pc", pc, held.pc);
            end else if (!prev_rst && !prev_ackedge) begin
                chk("instr_hold", instruction, prev_instr);
            end
            prev_req     = imem_req;
            prev_valid   = instr_valid;
            prev_ackedge = imem_req && imem_ack;
            prev_rst     = 1'b0;
        end
        prev_instr = instruction;
    end

    initial begin
        #1_000_000;
        checks++;
        failures++;
        $display("FAIL watchdog expired");
        finish_tb();
    end

    initial begin
        logic [7:0] jmp, tgt;
        logic [3:0] op;
        bit         branchy;
        rst         = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 8'h00;
        jump        = 8'h00;
        jump_target = 8'h00;
        stall       = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h00] = 8'hA2; mem[8'h01] = 8'h15; mem[8'h10] = 8'h3C; mem[8'h05] = 8'h81;
        mem[8'h40] = 8'h55; mem[8'h06] = 8'hB7; mem[8'hFF] = 8'hE1;
        m_addr = 8'h00;
        addr_q.push_back(8'h00);
        #2;
        chk("async_rst_req", imem_req, 1'b0);
        chk("async_rst_valid", instr_valid, 1'b0);
        step();
        step();
        rst = 1'b0;

        do_fetch(1, 0, 8'h00, 8'h00);  // 00 -> 01
        do_fetch(1, 0, JUMP_TAKEN, 8'h10);
        do_fetch(3, 0, JUMP_TAKEN, 8'h05);
        do_fetch(1, 0, JUMP_TAKEN, 8'h40);
        do_fetch(1, 0, JUMP_TAKEN, 8'h05);
        do_fetch(2, 0, 8'h0F, 8'h33);  // partial pattern: fall through to 06
        do_fetch(1, 4, 8'h00, 8'h00);  // B7 stalled with jump asserted, then 07
        do_fetch(1, 0, JUMP_TAKEN, 8'hFF);
        do_fetch(1, 0, 8'h00, 8'h00);  // FF wraps to 00
        do_fetch(1, 0, JUMP_TAKEN, 8'h00);  // self-loop
        do_fetch(1, 0, JUMP_TAKEN, 8'h22);

        // Reset while fetching 22, with acks in the reset cycle and the first cycle after it.
        wait_for(1'b0, "imem_req at 22");
        imem_ack = 1'b0;
        step();
        step();
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 8'h99;
        exp_q.delete();
        addr_q.delete();
        m_addr = 8'h00;
        addr_q.push_back(8'h00);
        #1;
        chk("rst_imm_req", imem_req, 1'b0);
        chk("rst_imm_pc", pc, 8'h00);
        step();
        rst = 1'b0;
        step();
        imem_ack = 1'b0;
        do_fetch(1, 0, 8'h00, 8'h00);

        for (int n = 0; n < 150; n++) begin
            op      = mem[m_addr][7:4];
            branchy = (op == OPCODE_J) || (op == OPCODE_JAL) || (op == OPCODE_BEQ) || (op == OPCODE_BNE);
            tgt     = 8'($urandom);
            if ($urandom_range(0, 9) < (branchy ? 7 : 3)) jmp = JUMP_TAKEN;
            else if ($urandom_range(0, 3) == 0) jmp = 8'($urandom_range(0, 254));
            else jmp = 8'h00;
            do_fetch($urandom_range(1, 4), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, jmp, tgt);
        end

        step();
        step();
        chk("exp_q_drained", exp_q.size(), 0);
        chk("addr_q_drained", addr_q.size(), 0);
        finish_tb();
    end

endmodule
